mpsoc_trace_arbiter: RTL and testbench
======================================

Name: mpsoc_trace_arbiter

Overview:
- Shares one trace output channel among the NUM_CORES per-core execution-trace streams of a compute tile (valid/pc/insn/wben/wbreg/wbdata per core).
- Buffers each stream in a small per-core FIFO and grants the channel round-robin.
- Detects per-core termination from a marker instruction and sequences the drain and done phase for the simulation/host side.

Parameters:
- NUM_CORES, 4: number of trace streams.
- FIFO_DEPTH, 4: entries per core FIFO; power of two, at least 2.
- TERM_INSN, 32'h15000001: committed instruction that marks core termination.
- ID_W, $clog2(NUM_CORES) (minimum 1): width of the core index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- trace_valid  input  NUM_CORES  per-core commit strobe.
- trace_pc  input  NUM_CORES*32  committed PC, core i at [32i+:32].
- trace_insn  input  NUM_CORES*32  committed instruction.
- trace_wben  input  NUM_CORES  register write-back enable.
- trace_wbreg  input  NUM_CORES*5  write-back register index.
- trace_wbdata  input  NUM_CORES*32  write-back data.
- out_valid  output  1  record available.
- out_ready  input  1  consumer accepts.
- out_id  output  ID_W  source core.
- out_pc, out_insn, out_wbdata  output  32 each  record fields.
- out_wben  output  1  record field.
- out_wbreg  output  5  record field.
- term  output  NUM_CORES  sticky per-core terminated flag.
- drop_flag  output  NUM_CORES  sticky per-core overflow flag.
- drop_cnt  output  16  saturating total of dropped records.
- done  output  1  all cores terminated and all records delivered.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, rr_ptr=NUM_CORES-1, state=RUN. All outputs 0: out_valid, out_* payload, term, drop_flag, drop_cnt, done.
- Push: trace_valid[i] && !term[i] writes a record into FIFO i at the clock edge. Records from a core whose term[i] is already set are ignored, not counted as drops.
- Full FIFO: a push is dropped, drop_flag[i] is set, and drop_cnt increments (saturates at 16'hFFFF). Multiple drops in one cycle add their count. Exception: a push and a pop of FIFO i in the same cycle when full is accepted.
- Termination: a pushed record with insn==TERM_INSN is stored and forwarded normally. term[i] is set at the same edge.
- Output stage is a registered slot. It loads when empty or when out_valid&&out_ready in this cycle (full throughput, 1 record/cycle).
- Grant: the first non-empty FIFO searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_CORES. rr_ptr is updated to the granted index. No grant leaves rr_ptr unchanged.
- Latency: trace_valid in cycle k gives out_valid in cycle k+2 if the slot is free and no other core wins.
- Hold rule: while out_valid && !out_ready, the payload and out_id stay stable. out_valid is never withdrawn without acceptance.
- FSM:
  - RUN -> DRAIN when term is all ones.
  - DRAIN -> DONE when all FIFOs are empty and (!out_valid or the slot is accepted this cycle with no refill).
  - DONE asserts done=1 and stays there until reset.
  - In DRAIN and DONE no pushes occur, since all term bits are set.
- Reset mid-operation discards all buffered records. Consumer-side reset behaviour is not defined here.

Decomposition:
- Shared package mpsoc_trace_pkg:
  - trace_rec_t packed struct: pc, insn, wben, wbreg, wbdata = 102 bits.
  - arb_state_e {RUN, DRAIN, DONE}.
  - TERM_INSN_DEFAULT.
- Sub-module mpsoc_trace_fifo (single-clock, depth FIFO_DEPTH, same-cycle push/pop when full, full/empty flags), instantiated NUM_CORES times.
- Round-robin search and FSM live in the top module.

Test Plan:
- Single core 0 push (pc=0x100, insn=0x13) with out_ready=1 in cycle 3 -> out_valid in cycle 5, out_id=0, out_pc=0x100, then idle.
- All 4 cores push every cycle for 8 cycles with out_ready=1 -> out_id sequence 0,1,2,3,0,… Each core loses records once its FIFO is full. drop_cnt equals pushes minus deliveries, with no reordering within a core.
- out_ready=0 for 10 cycles while core 2 pushes 6 records with FIFO_DEPTH=4 -> first record held stable, 1 in slot plus 4 buffered, 1 dropped. drop_flag=4'b0100, drop_cnt=1.
- Full FIFO with simultaneous pop and push -> push accepted, drop_cnt unchanged.
- Each core commits TERM_INSN at staggered times, with later records from terminated cores -> term bits set in order and later records never appear. done rises one cycle after the last record is accepted.
- Assert rst_n low mid-burst with out_valid=1 -> all outputs 0 immediately. After release, the first grant goes to core 0.

Source files
------------

// File: rtl/mpsoc_trace_pkg.sv
// Shared types and constants for the tile trace arbiter.
package mpsoc_trace_pkg;

    // One committed-instruction trace record (102 bits).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // Instruction that a core commits to signal it has finished.
    localparam logic [31:0] TERM_INSN_DEFAULT = 32'h15000001;

endpackage

// File: rtl/mpsoc_trace_fifo.sv
// Per-core trace record FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; the head record is visible combinationally.
module mpsoc_trace_fifo
    import mpsoc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t din,
    output trace_rec_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trace_rec_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr_reg];

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mpsoc_trace_arbiter.sv
// Merges per-core trace streams onto one output channel: per-core FIFOs,
// round-robin grant into a registered output slot, termination tracking and
// a RUN/DRAIN/DONE sequencer.
module mpsoc_trace_arbiter
    import mpsoc_trace_pkg::*;
#(
    parameter int          NUM_CORES  = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] TERM_INSN  = TERM_INSN_DEFAULT,
    parameter int          ID_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    trace_valid,
    input  logic [NUM_CORES*32-1:0] trace_pc,
    input  logic [NUM_CORES*32-1:0] trace_insn,
    input  logic [NUM_CORES-1:0]    trace_wben,
    input  logic [NUM_CORES*5-1:0]  trace_wbreg,
    input  logic [NUM_CORES*32-1:0] trace_wbdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_insn,
    output logic [31:0]             out_wbdata,
    output logic                    out_wben,
    output logic [4:0]              out_wbreg,
    output logic [NUM_CORES-1:0]    term,
    output logic [NUM_CORES-1:0]    drop_flag,
    output logic [15:0]             drop_cnt,
    output logic                    done
);

    trace_rec_t             push_rec [NUM_CORES];
    trace_rec_t             head_rec [NUM_CORES];
    logic [NUM_CORES-1:0]   push_req;
    logic [NUM_CORES-1:0]   pop;
    logic [NUM_CORES-1:0]   fifo_full;
    logic [NUM_CORES-1:0]   fifo_empty;
    logic [NUM_CORES-1:0]   drop;
    logic [NUM_CORES-1:0]   term_hit;

    logic                   out_valid_reg;
    trace_rec_t             out_rec_reg;
    logic [ID_W-1:0]        out_id_reg;
    logic [ID_W-1:0]        rr_ptr_reg;
    logic [NUM_CORES-1:0]   term_reg;
    logic [NUM_CORES-1:0]   drop_flag_reg;
    logic [15:0]            drop_cnt_reg;
    logic [15:0]            drop_cnt_next;
    logic [16:0]            drop_sum;
    arb_state_e             state_reg;
    logic                   done_reg;

    logic                   load;
    logic                   grant_found;
    logic [ID_W-1:0]        grant_idx;
    logic [ID_W-1:0]        cand;

    // The slot refills whenever it is empty or being consumed this cycle.
    assign load = !out_valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign push_rec[gi] = '{
                pc:     trace_pc[32*gi +: 32],
                insn:   trace_insn[32*gi +: 32],
                wben:   trace_wben[gi],
                wbreg:  trace_wbreg[5*gi +: 5],
                wbdata: trace_wbdata[32*gi +: 32]
            };
            // Terminated cores are silenced entirely, not counted as drops.
            assign push_req[gi] = trace_valid[gi] && !term_reg[gi];
            assign term_hit[gi] = push_req[gi] && (trace_insn[32*gi +: 32] == TERM_INSN);
            assign pop[gi]      = load && grant_found && (grant_idx == ID_W'(gi));
            assign drop[gi]     = push_req[gi] && fifo_full[gi] && !pop[gi];

            mpsoc_trace_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push_req[gi]),
                .pop   (pop[gi]),
                .din   (push_rec[gi]),
                .dout  (head_rec[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi])
            );
        end
    endgenerate

    // Round-robin search: first non-empty FIFO after the last granted core.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = ID_W'((int'(rr_ptr_reg) + k) % NUM_CORES);
            if (!grant_found && !fifo_empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Saturating accumulation of all drops occurring this cycle.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_reg};
        for (int i = 0; i < NUM_CORES; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_cnt_next = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    // Output slot, grant pointer and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_rec_reg   <= '0;
            out_id_reg    <= '0;
            rr_ptr_reg    <= ID_W'(NUM_CORES - 1);
            term_reg      <= '0;
            drop_flag_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (load) begin
                out_valid_reg <= grant_found;
                if (grant_found) begin
                    out_rec_reg <= head_rec[grant_idx];
                    out_id_reg  <= grant_idx;
                    rr_ptr_reg  <= grant_idx;
                end
            end
            term_reg      <= term_reg | term_hit;
            drop_flag_reg <= drop_flag_reg | drop;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    // Completion sequencer: wait for all terminations, then for the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (&term_reg) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((&fifo_empty) && (!out_valid_reg || out_ready)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_id     = out_id_reg;
    assign out_pc     = out_rec_reg.pc;
    assign out_insn   = out_rec_reg.insn;
    assign out_wben   = out_rec_reg.wben;
    assign out_wbreg  = out_rec_reg.wbreg;
    assign out_wbdata = out_rec_reg.wbdata;
    assign term       = term_reg;
    assign drop_flag  = drop_flag_reg;
    assign drop_cnt   = drop_cnt_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_mpsoc_trace_arbiter.sv
// Bench for mpsoc_trace_arbiter: queue-based reference model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_mpsoc_trace_arbiter;

    localparam int          NC    = 4;
    localparam int          DEPTH = 4;
    localparam int          IDW   = 2;
    localparam logic [31:0] TERM  = 32'h15000001;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } rec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NC-1:0]       trace_valid = '0;
    logic [NC*32-1:0]    trace_pc = '0;
    logic [NC*32-1:0]    trace_insn = '0;
    logic [NC-1:0]       trace_wben = '0;
    logic [NC*5-1:0]     trace_wbreg = '0;
    logic [NC*32-1:0]    trace_wbdata = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [IDW-1:0]      out_id;
    logic [31:0]         out_pc;
    logic [31:0]         out_insn;
    logic [31:0]         out_wbdata;
    logic                out_wben;
    logic [4:0]          out_wbreg;
    logic [NC-1:0]       term;
    logic [NC-1:0]       drop_flag;
    logic [15:0]         drop_cnt;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;
    int seq_ctr  = 0;
    bit chk_en   = 1'b0;

    mpsoc_trace_arbiter #(
        .NUM_CORES  (NC),
        .FIFO_DEPTH (DEPTH),
        .TERM_INSN  (TERM),
        .ID_W       (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_pc       (out_pc),
        .out_insn     (out_insn),
        .out_wbdata   (out_wbdata),
        .out_wben     (out_wben),
        .out_wbreg    (out_wbreg),
        .term         (term),
        .drop_flag    (drop_flag),
        .drop_cnt     (drop_cnt),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    rec_t          mq [NC][$];
    rec_t          m_slot;
    logic          m_valid = 1'b0;
    int            m_id    = 0;
    int            m_rr    = NC - 1;
    logic [NC-1:0] m_term  = '0;
    logic [NC-1:0] m_dflag = '0;
    int            m_dcnt  = 0;
    bit            m_drain = 1'b0;
    bit            m_done  = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int            g;
        int            c;
        int            nd;
        bit            all_empty;
        bit            slot_free;
        logic [NC-1:0] told;
        rec_t          r;
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            m_valid = 1'b0;
            m_id    = 0;
            m_rr    = NC - 1;
            m_term  = '0;
            m_dflag = '0;
            m_dcnt  = 0;
            m_drain = 1'b0;
            m_done  = 1'b0;
        end else begin
            all_empty = 1'b1;
            for (int i = 0; i < NC; i++) if (mq[i].size() != 0) all_empty = 1'b0;
            slot_free = !m_valid || out_ready;
            // completion: after every core terminated, the first cycle where
            // nothing is buffered and the slot is free or being taken
            if (m_drain && all_empty && slot_free) m_done = 1'b1;
            if (&m_term) m_drain = 1'b1;
            // deliver: next non-empty core after the previous winner
            if (slot_free) begin
                g = -1;
                for (int k = 1; k <= NC; k++) begin
                    c = (m_rr + k) % NC;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    m_slot  = mq[g].pop_front();
                    m_id    = g;
                    m_rr    = g;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            // accept new commits (space freed by this cycle's pop counts)
            told = m_term;
            nd   = 0;
            for (int i = 0; i < NC; i++) begin
                if (trace_valid[i] && !told[i]) begin
                    r.pc     = trace_pc[32*i +: 32];
                    r.insn   = trace_insn[32*i +: 32];
                    r.wben   = trace_wben[i];
                    r.wbreg  = trace_wbreg[5*i +: 5];
                    r.wbdata = trace_wbdata[32*i +: 32];
                    if (mq[i].size() < DEPTH) mq[i].push_back(r);
                    else begin
                        nd++;
                        m_dflag[i] = 1'b1;
                    end
                    if (r.insn == TERM) m_term[i] = 1'b1;
                end
            end
            m_dcnt = (m_dcnt + nd > 65535) ? 65535 : m_dcnt + nd;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("out_id", 64'(out_id), 64'(m_id));
                chk("out_pc", 64'(out_pc), 64'(m_slot.pc));
                chk("out_insn", 64'(out_insn), 64'(m_slot.insn));
                chk("out_wben", 64'(out_wben), 64'(m_slot.wben));
                chk("out_wbreg", 64'(out_wbreg), 64'(m_slot.wbreg));
                chk("out_wbdata", 64'(out_wbdata), 64'(m_slot.wbdata));
            end
            chk("term", 64'(term), 64'(m_term));
            chk("drop_flag", 64'(drop_flag), 64'(m_dflag));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
            chk("done", 64'(done), 64'(m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] pc, input logic [31:0] insn);
        seq_ctr = seq_ctr + 1;
        trace_valid[i]           = 1'b1;
        trace_pc[32*i +: 32]     = pc;
        trace_insn[32*i +: 32]   = insn;
        trace_wben[i]            = seq_ctr[0];
        trace_wbreg[5*i +: 5]    = seq_ctr[4:0];
        trace_wbdata[32*i +: 32] = pc ^ 32'hA5A5_0000 ^ 32'(seq_ctr);
    endtask

    function automatic logic [31:0] mkpc(input int i);
        return 32'h1000_0000 | (32'(i) << 16) | 32'(seq_ctr & 16'hFFFF);
    endfunction

    task automatic idle();
        trace_valid = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        // reset values
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_term", 64'(term), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();
        $display("reset released");

        // 1: single core-0 record, two-cycle latency, then idle
        out_ready = 1'b1;
        drive(0, 32'h100, NOP);
        step();
        idle();
        chk("t1_lat1_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_id", 64'(out_id), 64'd0);
        chk("t1_pc", 64'(out_pc), 64'h100);
        step();
        chk("t1_idle", 64'(out_valid), 64'd0);
        $display("txn single core0 pc=100 delivered");

        // 2: all cores every cycle for 8 cycles
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NC; i++) drive(i, mkpc(i), NOP + 32'(c << 12));
            step();
            if (c >= 1) chk("t2_rr_id", 64'(out_id), 64'((c - 1) % NC));
            $display("txn burst cycle %0d out_id=%0d drop_cnt=%0d", c, out_id, drop_cnt);
        end
        idle();
        chk("t2_drop_cnt", 64'(drop_cnt), 64'd9);
        chk("t2_drop_flag", 64'(drop_flag), 64'hF);
        for (int c = 0; c < 24; c++) step();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // 3: stalled consumer, core 2 pushes six records
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            drive(2, 32'h2000 + 32'(n), NOP);
            step();
            $display("txn stall push core2 n=%0d out_pc=%0h", n, out_pc);
        end
        idle();
        for (int n = 0; n < 4; n++) step();
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_pc_held", 64'(out_pc), 64'h2000);
        chk("t3_drop_flag", 64'(drop_flag), 64'h4);
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);

        // 4: full FIFO with simultaneous pop and push
        out_ready = 1'b1;
        drive(2, 32'h2006, NOP);
        step();
        idle();
        chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t4_pc", 64'(out_pc), 64'h2001);
        $display("txn full push+pop core2 drop_cnt=%0d", drop_cnt);
        for (int n = 0; n < 10; n++) step();
        chk("t4_drained", 64'(out_valid), 64'd0);

        // 5: staggered termination with late records from finished cores
        do_reset();
        drive(0, 32'h5000, TERM);
        drive(1, 32'h5100, NOP);
        step();
        idle();
        chk("t5_term0", 64'(term), 64'h1);
        drive(0, 32'h5EEE, NOP);
        drive(2, 32'h5200, NOP);
        step();
        idle();
        drive(1, 32'h5101, TERM);
        drive(3, 32'h5300, NOP);
        step();
        idle();
        chk("t5_term1", 64'(term), 64'h3);
        drive(0, 32'h5EEF, NOP);
        drive(1, 32'h5EF0, NOP);
        drive(2, 32'h5201, TERM);
        step();
        idle();
        chk("t5_term2", 64'(term), 64'h7);
        drive(2, 32'h5EF1, NOP);
        drive(3, 32'h5301, TERM);
        step();
        idle();
        chk("t5_term3", 64'(term), 64'hF);
        begin
            int budget = 0;
            while (!done && budget < 40) begin
                step();
                budget++;
            end
        end
        chk("t5_done", 64'(done), 64'd1);
        $display("txn termination sequence done=%0d", done);

        // 6: reset in the middle of a burst
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NC; i++) drive(i, mkpc(i), NOP);
            step();
        end
        chk("t6_busy", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_pc", 64'(out_pc), 64'd0);
        chk("t6_async_drop", 64'(drop_cnt), 64'd0);
        idle();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NC; i++) drive(i, mkpc(i), NOP);
        step();
        idle();
        step();
        chk("t6_first_valid", 64'(out_valid), 64'd1);
        chk("t6_first_id", 64'(out_id), 64'd0);
        $display("txn post-reset first grant id=%0d", out_id);
        for (int n = 0; n < 8; n++) step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
